// File: rtl/hdd_pkg.sv
// Shared widths, reset values and field-select encodings for the hour/date/day register bank.
package hdd_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned DATE_W = 5;
    localparam int unsigned DAY_W  = 3;
    localparam int unsigned BUS_W  = 6;

    localparam int unsigned HOUR_RST = 0;
    localparam int unsigned DATE_RST = 1;
    localparam int unsigned DAY_RST  = 0;

    typedef enum logic [1:0] {
        SEL_HOUR = 2'd0,
        SEL_DATE = 2'd1,
        SEL_DAY  = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

endpackage

// File: rtl/wrap_counter.sv
// Loadable wrap-around counter.
// The counter restarts at MIN once its value has reached the limit, and it also wraps from any
// value above the limit. The limit is the MAX parameter, or the max_in port when DYN_MAX is set.
// The wrap output is combinational: it is high in a cycle where an increment wraps the counter.
module wrap_counter #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MIN     = 0,
    parameter int unsigned MAX     = 23,
    parameter bit          DYN_MAX = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] max_in,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] limit;
    logic             at_max;

    assign limit  = DYN_MAX ? max_in : WIDTH'(MAX);
    // ">=" rather than "==" so a value left above a shrunken limit still wraps
    assign at_max = (value_q >= limit);
    assign wrap   = inc && !clear && !load && at_max;
    assign value  = value_q;

    // Next value: clear over load over increment
    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = WIDTH'(MIN);
        end else if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = at_max ? WIDTH'(MIN) : value_q + WIDTH'(1);
        end
    end

    // Counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= WIDTH'(MIN);
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/hour_date_day_regs.sv
// Hour, date-of-month and day-of-week register bank on the shared field databus.
// Each field can be loaded, cleared or read back. The hour-advance strobe ripples its carry into
// the date and weekday fields.
// Build option: define LOAD_CHECK_EN to reject out-of-range loads. A rejected load leaves the field
// unchanged and raises a load_err pulse.
module hour_date_day_regs #(
    parameter int unsigned HOUR_MAX = 23,
    parameter int unsigned DAY_MAX  = 6,
    parameter int unsigned BUS_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       sel,
    input  logic [BUS_W-1:0] bus_in,
    input  logic             inc,
    input  logic [4:0]       month_len,
    output logic [4:0]       hour,
    output logic [4:0]       date,
    output logic [2:0]       day,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe,
    output logic             date_carry,
    output logic             load_err
);

    import hdd_pkg::*;

    logic field_load;
    logic inc_eff;
    logic hour_ok, date_ok, day_ok;
    logic load_hour, load_date, load_day;
    logic hour_wrap, date_wrap, day_wrap;
    logic date_carry_q;

    // A load that targets a real field drops that cycle's increment, even when the load is rejected
    assign field_load = load && (sel != SEL_NONE);
    assign inc_eff    = inc && !clear && !field_load;

`ifdef LOAD_CHECK_EN
    logic load_err_q;
    logic load_err_d;

    // The range check uses the full bus value, so wide values cannot alias into range
    assign hour_ok = (32'(bus_in) <= HOUR_MAX);
    assign date_ok = (bus_in != '0) && (32'(bus_in) <= 32'(month_len));
    assign day_ok  = (32'(bus_in) <= DAY_MAX);

    assign load_err_d = load && !clear && (((sel == SEL_HOUR) && !hour_ok) ||
                                           ((sel == SEL_DATE) && !date_ok) ||
                                           ((sel == SEL_DAY)  && !day_ok));

    // Registered one-cycle rejected-load pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;
`else
    assign hour_ok  = 1'b1;
    assign date_ok  = 1'b1;
    assign day_ok   = 1'b1;
    assign load_err = 1'b0;
`endif

    assign load_hour = load && (sel == SEL_HOUR) && hour_ok;
    assign load_date = load && (sel == SEL_DATE) && date_ok;
    assign load_day  = load && (sel == SEL_DAY)  && day_ok;

    wrap_counter #(
        .WIDTH   (HOUR_W),
        .MIN     (HOUR_RST),
        .MAX     (HOUR_MAX),
        .DYN_MAX (1'b0)
    ) u_hour (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .load     (load_hour),
        .load_val (bus_in[HOUR_W-1:0]),
        .inc      (inc_eff),
        .max_in   (HOUR_W'(HOUR_MAX)),
        .value    (hour),
        .wrap     (hour_wrap)
    );

    wrap_counter #(
        .WIDTH   (DATE_W),
        .MIN     (DATE_RST),
        .MAX     (31),
        .DYN_MAX (1'b1)
    ) u_date (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .load     (load_date),
        .load_val (bus_in[DATE_W-1:0]),
        .inc      (hour_wrap),
        .max_in   (month_len),
        .value    (date),
        .wrap     (date_wrap)
    );

    wrap_counter #(
        .WIDTH   (DAY_W),
        .MIN     (DAY_RST),
        .MAX     (DAY_MAX),
        .DYN_MAX (1'b0)
    ) u_day (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .load     (load_day),
        .load_val (bus_in[DAY_W-1:0]),
        .inc      (hour_wrap),
        .max_in   (DAY_W'(DAY_MAX)),
        .value    (day),
        .wrap     (day_wrap)
    );

    // The weekday wrap is not exported; only the date carry feeds the month register
    logic unused_sig;
    assign unused_sig = day_wrap;

    // Registered one-cycle date-rollover pulse for the month register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            date_carry_q <= 1'b0;
        end else begin
            date_carry_q <= date_wrap;
        end
    end

    assign date_carry = date_carry_q;
    assign bus_oe     = enable;

    // Read-back mux: the selected field is zero-extended, and the mux drives 0 when idle
    always_comb begin
        bus_out = '0;
        if (enable) begin
            case (sel_e'(sel))
                SEL_HOUR: bus_out = BUS_W'(hour);
                SEL_DATE: bus_out = BUS_W'(date);
                SEL_DAY:  bus_out = BUS_W'(day);
                default:  bus_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hour_date_day_regs.sv
// Self-checking bench for hour_date_day_regs.
// The bench runs directed scenarios and then randomized traffic. Both are checked against a
// calendar model that is kept as plain integers.
module tb_hour_date_day_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, clear, enable, inc;
    logic [1:0] sel;
    logic [5:0] bus_in;
    logic [4:0] month_len;
    logic [4:0] hour, date;
    logic [2:0] day;
    logic [5:0] bus_out;
    logic       bus_oe, date_carry, load_err;

    hour_date_day_regs #(
        .HOUR_MAX (23),
        .DAY_MAX  (6),
        .BUS_W    (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .clear      (clear),
        .enable     (enable),
        .sel        (sel),
        .bus_in     (bus_in),
        .inc        (inc),
        .month_len  (month_len),
        .hour       (hour),
        .date       (date),
        .day        (day),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .date_carry (date_carry),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference calendar state
    int m_hour, m_date, m_day;
    int m_carry, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_bus(input int en, input int s);
        if (en == 0) return 0;
        case (s)
            0:       return m_hour;
            1:       return m_date;
            2:       return m_day;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_hour  = 0;
        m_date  = 1;
        m_day   = 0;
        m_carry = 0;
        m_err   = 0;
    endtask

    // One clock edge of calendar behaviour
    task automatic model_edge(input int ld, input int clr, input int in, input int s,
                              input int b, input int ml);
        int ok;
        m_carry = 0;
        m_err   = 0;
        if (clr != 0) begin
            m_hour = 0;
            m_date = 1;
            m_day  = 0;
        end else if (ld != 0 && s != 3) begin
`ifdef LOAD_CHECK_EN
            if (s == 0)      ok = (b <= 23) ? 1 : 0;
            else if (s == 1) ok = (b >= 1 && b <= ml) ? 1 : 0;
            else             ok = (b <= 6) ? 1 : 0;
`else
            ok = 1;
`endif
            if (ok == 0) begin
                m_err = 1;
            end else if (s == 0) begin
                m_hour = b % 32;
            end else if (s == 1) begin
                m_date = b % 32;
            end else begin
                m_day = b % 8;
            end
        end else if (in != 0) begin
            if (m_hour >= 23) begin
                m_hour = 0;
                m_day  = (m_day >= 6) ? 0 : m_day + 1;
                if (m_date >= ml) begin
                    m_date  = 1;
                    m_carry = 1;
                end else begin
                    m_date = m_date + 1;
                end
            end else begin
                m_hour = m_hour + 1;
            end
        end
    endtask

    task automatic compare_all(input string tag, input int en, input int s);
        check({tag, ".hour"},  32'(hour),       32'(m_hour));
        check({tag, ".date"},  32'(date),       32'(m_date));
        check({tag, ".day"},   32'(day),        32'(m_day));
        check({tag, ".carry"}, 32'(date_carry), 32'(m_carry));
        check({tag, ".err"},   32'(load_err),   32'(m_err));
        check({tag, ".bus"},   32'(bus_out),    32'(model_bus(en, s)));
        check({tag, ".oe"},    32'(bus_oe),     32'(en));
    endtask

    // Drive one cycle from a negedge, then check 1 time unit after the posedge
    task automatic step(input string tag, input int ld, input int clr, input int in,
                        input int en, input int s, input int b, input int ml);
        load      = ld[0];
        clear     = clr[0];
        inc       = in[0];
        enable    = en[0];
        sel       = s[1:0];
        bus_in    = b[5:0];
        month_len = ml[4:0];
        model_edge(ld, clr, in, s, b, ml);
        @(posedge clk);
        #1;
        compare_all(tag, en, s);
        @(negedge clk);
    endtask

    initial begin
        int ml;
        int r, ld, clr, in, en, s, b;

        rst_n = 1'b0;
        load = 1'b0; clear = 1'b0; enable = 1'b0; inc = 1'b0;
        sel = 2'd3; bus_in = '0; month_len = 5'd31;
        model_reset();
        #12;
        compare_all("reset", 0, 3);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            sel    = i[1:0];
            #1;
            check("reset_bus", 32'(bus_out), 32'(model_bus(1, i)));
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Read back, then force a full rollover from hour 23, date 31, day 6
        step("rd_date", 0, 0, 0, 1, 1, 0, 31);
        step("ld_h23",  1, 0, 0, 1, 0, 23, 31);
        step("ld_d31",  1, 0, 0, 1, 1, 31, 31);
        step("ld_w6",   1, 0, 0, 1, 2, 6, 31);
        step("roll",    0, 0, 1, 1, 1, 0, 31);
        step("roll_nx", 0, 0, 0, 1, 2, 0, 31);

        // One day of increments from date 15
        step("ld_d15", 1, 0, 0, 1, 1, 15, 31);
        for (int i = 0; i < 24; i++) step("day_inc", 0, 0, 1, 1, 1, 0, 31);
        check("day_inc_date", 32'(date), 32'd16);

        // Priority checks
        step("ld_h7",   1, 0, 0, 1, 0, 7, 31);
        step("ld_clr",  1, 1, 1, 1, 0, 10, 31);
        step("ld_inc",  1, 0, 1, 1, 0, 10, 31);
        check("ld_inc_hour", 32'(hour), 32'd10);
        step("ld3_inc", 1, 0, 1, 1, 3, 5, 31);

        // Out-of-range loads
        step("ld_h30",  1, 0, 0, 1, 0, 30, 31);
        step("inc_h30", 0, 0, 1, 1, 0, 0, 31);
        step("ld_d0",   1, 0, 0, 1, 1, 0, 28);
        step("ld_w7",   1, 0, 0, 1, 2, 7, 28);
        step("ld_d30",  1, 0, 0, 1, 1, 30, 28);
        step("ld_h23b", 1, 0, 0, 1, 0, 23, 28);
        step("inc_wrp", 0, 0, 1, 1, 1, 0, 28);

        // Asynchronous reset between edges while date_carry is high
        step("ld_h23c", 1, 0, 0, 1, 0, 23, 28);
        step("ld_d28",  1, 0, 0, 1, 1, 28, 28);
        step("carry_c", 0, 0, 1, 1, 1, 0, 28);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.hour",  32'(hour),       32'd0);
        check("arst.date",  32'(date),       32'd1);
        check("arst.day",   32'(day),        32'd0);
        check("arst.carry", 32'(date_carry), 32'd0);
        check("arst.err",   32'(load_err),   32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        ml = 31;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) ml = 28 + $urandom_range(0, 3);
            r   = $urandom_range(0, 99);
            clr = (r < 2) ? 1 : 0;
            ld  = (r >= 2 && r < 12) ? 1 : 0;
            in  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            en  = $urandom_range(0, 1);
            s   = $urandom_range(0, 3);
            b   = $urandom_range(0, 63);
            step("rand", ld, clr, in, en, s, b, ml);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hour_date_day_regs.md
Name: hour_date_day_regs

Overview:
- Register bank for the hour, date-of-month and day-of-week fields of the digital clock/calendar.
- Each field can be loaded from the shared 6-bit data bus, cleared, or read back onto the bus through a select code.
- An hour-advance strobe increments the hour. Rollover ripples into date and weekday.
- Sits beside the second/minute/month/year field registers on the same databus.

Parameters:
- HOUR_MAX, 23, last valid hour before wrap to 0
- DAY_MAX, 6, last valid weekday before wrap to 0
- BUS_W, 6, data bus width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  write bus_in into the selected field
- clear  in  1  synchronous clear of all three fields to reset values
- enable  in  1  drive the selected field onto bus_out
- sel  in  2  field select: 0 = hour, 1 = date, 2 = day, 3 = none
- bus_in  in  BUS_W  data bus input
- inc  in  1  advance hour by one
- month_len  in  5  days in current month, 28..31
- hour  out  5  current hour, 0..23
- date  out  5  current date, 1..month_len
- day  out  3  current weekday, 0..6
- bus_out  out  BUS_W  selected field zero-extended; 0 when enable=0 or sel=3
- bus_oe  out  1  equals enable
- date_carry  out  1  one-cycle pulse when the date wraps to 1 (feeds the month register)
- load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (rst_n=0, asynchronous) values:
  - hour=0, date=1, day=0
  - date_carry=0, load_err=0
- Per-cycle priority: clear > load > inc.
- clear=1: all fields return to reset values next edge; load and inc are ignored that cycle.
- load=1, sel=0..2: the selected field takes bus_in truncated to its width, next edge.
  - inc in the same cycle is dropped entirely, including any carry.
  - load with sel=3 is a no-op and leaves inc unaffected.
- Range rules on load:
  - hour must be 0..23.
  - date must be 1..month_len.
  - day must be 0..6.
  - Out-of-range rule depends on LOAD_CHECK_EN (see Optional Feature).
- inc=1 with no clear or load:
  - hour<23: hour+1.
  - hour=23: hour=0, day advances (6 wraps to 0), date advances.
  - date advances as date+1; if date >= month_len, date=1 and date_carry pulses.
  - A date already above month_len after a month change wraps to 1 on the next rollover.
- bus_out is combinational from the current registers; latency 0.
- date_carry and load_err are registered, high exactly one cycle.
- Reset asserted mid-operation overrides everything immediately.

Optional Feature:
- Macro LOAD_CHECK_EN.
- Defined:
  - Out-of-range loads leave the field unchanged and pulse load_err next cycle.
  - date=0 is rejected.
- Undefined:
  - Loads write the truncated value unconditionally.
  - load_err is tied 0.
  - Subsequent inc still wraps: hour >= 23 goes to 0, and day >= 6 goes to 0.

Decomposition:
- Package hdd_pkg holds:
  - width constants HOUR_W=5, DATE_W=5, DAY_W=3, BUS_W=6
  - reset constants HOUR_RST=0, DATE_RST=1, DAY_RST=0
  - sel encodings SEL_HOUR, SEL_DATE, SEL_DAY, SEL_NONE
- Sub-module wrap_counter: parameterised width, min and max; load, clear and inc inputs; wrap output. Instantiated three times, with the date instance taking a dynamic max from month_len.

Test Plan:
- Reset then enable=1, sel=1 -> bus_out=6'd1. With sel=0 -> 0. With sel=2 -> 0. hour=0, date=1, day=0.
- load=1, sel=0, bus_in=23; then inc for 1 cycle with month_len=31, date=31, day=6 -> hour=0, date=1, day=0, date_carry high one cycle.
- load sel=1 bus_in=15, then 24 inc pulses -> date=16, hour unchanged from its start value, day+1.
- load and clear together with sel=0, bus_in=10 -> hour=0, date=1, day=0. load and inc together -> loaded value, no increment.
- With LOAD_CHECK_EN: load sel=0 bus_in=30 -> hour unchanged, load_err pulses. Without it: hour=30, then inc -> hour=0.
- Assert rst_n low between clock edges mid-count -> outputs return to reset values immediately, not at the next edge.
